// File: rtl/button_edge_detect.sv
// rtl/button_edge_detect.sv - multi-channel synchronised, debounced button edge detector
//
// Each channel synchronises its raw button level, debounces it with its own
// counter and emits a one-cycle pulse when the debounced level toggles in a
// direction enabled by edge_mode. A sticky pending flag records each pulse
// until the consumer clears it.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-low reset
//   button_in    [N_CH]  raw asynchronous button levels
//   edge_mode    [2]     00 off, 01 rising, 10 falling, 11 both
//   clear        [N_CH]  per-channel pending clear, sampled on posedge
//   level_out    [N_CH]  debounced stable level
//   pulse_out    [N_CH]  one-cycle edge pulse
//   pending      [N_CH]  sticky edge-seen flag
//   any_pending  OR of pending

module button_edge_detect #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button_in,
  input  logic [1:0]      edge_mode,
  input  logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] pending,
  output logic            any_pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   pend_q;
    logic                   synced;
    logic                   accept;
    logic                   pulse_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only advances while synced disagrees with the accepted
    // level, so reaching CNT_MAX with a disagreement means the new level has
    // held for DEBOUNCE_CYCLES consecutive samples.
    assign accept = (synced != level_q) && (cnt_q == CNT_MAX);

    // Direction of the toggle selects which edge_mode bit gates the pulse;
    // synced is the level being adopted.
    assign pulse_d = accept && (synced ? edge_mode[0] : edge_mode[1]);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], button_in[i]};

        if (synced == level_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          cnt_q   <= '0;
          level_q <= synced;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end

        pulse_q <= pulse_d;
        // A new pulse takes priority over a simultaneous clear.
        pend_q  <= pulse_d | (pend_q & ~clear[i]);
      end
    end

    assign level_out[i] = level_q;
    assign pulse_out[i] = pulse_q;
    assign pending[i]   = pend_q;
  end

  assign any_pending = |pending;

endmodule
